// File: rtl/em_pkg.sv
// Shared definitions for the electromagnet gripper driver: FSM state
// encodings, the default pickup-node mask and a limit helper.
package em_pkg;

  // Per-channel FSM state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PULLIN = 3'd1;
  localparam logic [2:0] ST_HOLD   = 3'd2;
  localparam logic [2:0] ST_DEMAG  = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  // Nodes 10, 11, 22 and 23 are pickup points
  localparam logic [31:0] DEFAULT_LATCH_MASK = 32'h00C0_0C00;

  // A zero-length limit behaves like a one-cycle limit
  function automatic int unsigned lim1(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/em_channel.sv
// One magnet channel: latch/hold/release FSM with its pull-in, demag and
// grip-confirm counters. Emits next-cycle drive bits so the top-level
// output registers line up with the state register.
module em_channel
  import em_pkg::*;
#(
  parameter int unsigned PULLIN_CYC   = 50000,
  parameter int unsigned GRIP_TIMEOUT = 500000,
  parameter int unsigned DEMAG_CYC    = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  input  logic delatch_i,
  input  logic grip_ok_i,
  input  logic pwm_hi_i,   // PWM high phase for the cycle after this edge
  output logic drv_o1_o,   // forward drive to register at this edge
  output logic drv_o2_o,   // reverse drive to register at this edge
  output logic latched_o,
  output logic fault_o
);

  localparam int unsigned PL   = lim1(PULLIN_CYC);
  localparam int unsigned GT   = lim1(GRIP_TIMEOUT);
  localparam int unsigned DC   = lim1(DEMAG_CYC);
  localparam int unsigned PL_W = $clog2(PL) + 1;
  localparam int unsigned GT_W = $clog2(GT) + 1;
  localparam int unsigned DC_W = $clog2(DC) + 1;

  logic [2:0]      state_q, state_d;
  logic [PL_W-1:0] pc_q, pc_d;
  logic [GT_W-1:0] gc_q, gc_d;
  logic [DC_W-1:0] dc_q, dc_d;

  // Next-state and counter update; delatch outranks trigger and timeout
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    gc_d    = gc_q;
    dc_d    = dc_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_i && !delatch_i) begin
          state_d = ST_PULLIN;
          pc_d    = '0;
        end
      end
      ST_PULLIN: begin
        if (delatch_i) begin
          state_d = ST_DEMAG;
          dc_d    = '0;
          pc_d    = '0;
        end else if (pc_q == PL_W'(PL - 1)) begin
          state_d = ST_HOLD;
          pc_d    = '0;
          gc_d    = '0;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (delatch_i) begin
          state_d = ST_DEMAG;
          dc_d    = '0;
          gc_d    = '0;
        end else if (grip_ok_i) begin
          gc_d = '0;
        end else begin
          gc_d = gc_q + 1'b1;
          if (gc_q == GT_W'(GT - 1)) state_d = ST_FAULT;
        end
      end
      ST_DEMAG: begin
        if (dc_q == DC_W'(DC - 1)) begin
          state_d = ST_IDLE;
          dc_d    = '0;
        end else begin
          dc_d = dc_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (delatch_i) begin
          state_d = ST_IDLE;
          gc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        gc_d    = '0;
        dc_d    = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      gc_q    <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      gc_q    <= gc_d;
      dc_q    <= dc_d;
    end
  end

  // Drive decode from the upcoming state so outputs move on the same edge
  always_comb begin
    drv_o1_o = 1'b0;
    drv_o2_o = 1'b0;
    if (!rst) begin
      drv_o1_o = (state_d == ST_PULLIN) || ((state_d == ST_HOLD) && pwm_hi_i);
      drv_o2_o = (state_d == ST_DEMAG);
    end
  end

  assign latched_o = (state_q == ST_PULLIN) || (state_q == ST_HOLD);
  assign fault_o   = (state_q == ST_FAULT);

endmodule

// File: rtl/electromagnet_ctrl.sv
// Multi-channel electromagnet driver: decodes node-triggered latch
// requests, runs the shared hold PWM counter and registers the H-bridge
// outputs for every channel.
module electromagnet_ctrl
  import em_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned NODE_W       = 5,
  parameter logic [2**NODE_W-1:0] LATCH_MASK = DEFAULT_LATCH_MASK,
  parameter int unsigned PULLIN_CYC   = 50000,
  parameter int unsigned PWM_PERIOD   = 100,
  parameter int unsigned HOLD_DUTY    = 40,
  parameter int unsigned GRIP_TIMEOUT = 500000,
  parameter int unsigned DEMAG_CYC    = 5000,
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NODE_W-1:0] future_node,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [N_CH-1:0]   delatch,
  input  logic [N_CH-1:0]   grip_ok,
  output logic [N_CH-1:0]   o1,
  output logic [N_CH-1:0]   o2,
  output logic [N_CH-1:0]   latched,
  output logic [N_CH-1:0]   fault
);

  localparam int unsigned PP    = lim1(PWM_PERIOD);
  localparam int unsigned PWM_W = $clog2(PP) + 1;

  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             pwm_hi_d;
  logic             node_hit;
  logic [N_CH-1:0]  trig;
  logic [N_CH-1:0]  drv_o1, drv_o2;
  logic [N_CH-1:0]  o1_q, o2_q;

  // Free-running hold PWM counter, wraps at the period
  always_comb begin
    if (rst || (pwm_q == PWM_W'(PP - 1))) pwm_d = '0;
    else                                  pwm_d = pwm_q + 1'b1;
  end

  assign pwm_hi_d = (32'(pwm_d) < HOLD_DUTY);

  // PWM counter register
  always_ff @(posedge clk) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_d;
  end

  assign node_hit = en && LATCH_MASK[future_node];

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    assign trig[i] = node_hit && (int'(ch_sel) == i);

    em_channel #(
      .PULLIN_CYC  (PULLIN_CYC),
      .GRIP_TIMEOUT(GRIP_TIMEOUT),
      .DEMAG_CYC   (DEMAG_CYC)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .trig_i   (trig[i]),
      .delatch_i(delatch[i]),
      .grip_ok_i(grip_ok[i]),
      .pwm_hi_i (pwm_hi_d),
      .drv_o1_o (drv_o1[i]),
      .drv_o2_o (drv_o2[i]),
      .latched_o(latched[i]),
      .fault_o  (fault[i])
    );
  end

  // Registered H-bridge outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      o1_q <= '0;
      o2_q <= '0;
    end else begin
      o1_q <= drv_o1;
      o2_q <= drv_o2;
    end
  end

  assign o1 = o1_q;
  assign o2 = o2_q;

endmodule

// File: tb/tb_electromagnet_ctrl.sv
// Directed bench for electromagnet_ctrl with short timing parameters.
module tb_electromagnet_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [4:0] future_node = '0;
  logic [0:0] ch_sel = '0;
  logic [1:0] delatch = '0;
  logic [1:0] grip_ok = '0;
  logic [1:0] o1, o2, latched, fault;

  int checks = 0;
  int errors = 0;
  int pwm_m = 0;

  electromagnet_ctrl #(
    .N_CH(2), .NODE_W(5), .PULLIN_CYC(4), .PWM_PERIOD(4),
    .HOLD_DUTY(1), .GRIP_TIMEOUT(8), .DEMAG_CYC(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .future_node(future_node),
    .ch_sel(ch_sel), .delatch(delatch), .grip_ok(grip_ok),
    .o1(o1), .o2(o2), .latched(latched), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference free-running PWM phase
  always @(posedge clk) begin
    if (rst) pwm_m <= 0;
    else     pwm_m <= (pwm_m == 3) ? 0 : pwm_m + 1;
  end

  // Forward and reverse drive must never overlap
  always @(negedge clk) begin
    checks++;
    if ((o1 & o2) !== 2'b00) begin
      errors++;
      $display("FAIL safety: o1=%b o2=%b required o1&o2=00", o1, o2);
    end
  end

  task automatic trigger(input logic [4:0] node, input logic ch, input logic e);
    future_node = node; ch_sel = ch; en = e;
    @(negedge clk);
    en = 1'b0; future_node = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o1, o2, latched, fault} !== 8'h00) begin
      errors++;
      $display("FAIL reset: o1=%b o2=%b latched=%b fault=%b required all 0", o1, o2, latched, fault);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latch;
    grip_ok = 2'b11;
    trigger(5'd22, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (o1 !== 2'b10 || o2 !== 2'b00 || latched !== 2'b10) begin
        errors++;
        $display("FAIL pullin[%0d]: o1=%b o2=%b latched=%b required 10 00 10", k, o1, o2, latched);
      end
      @(negedge clk);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (o1 !== {(pwm_m == 0), 1'b0} || o2 !== 2'b00 || latched !== 2'b10) begin
        errors++;
        $display("FAIL hold_pwm[%0d]: o1=%b latched=%b required o1=%b latched=10", k, o1, latched, {(pwm_m == 0), 1'b0});
      end
      @(negedge clk);
    end
    delatch = 2'b10;
    @(negedge clk);
    delatch = 2'b00;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o1 !== 2'b00 || o2 !== 2'b10) begin
        errors++;
        $display("FAIL demag_ch1[%0d]: o1=%b o2=%b required 00 10", k, o1, o2);
      end
      @(negedge clk);
    end
    checks++;
    if (o1 !== 2'b00 || o2 !== 2'b00 || latched !== 2'b00) begin
      errors++;
      $display("FAIL idle_ch1: o1=%b o2=%b latched=%b required 00 00 00", o1, o2, latched);
    end
  endtask

  task automatic test_no_trigger;
    future_node = 5'd5; ch_sel = 1'b0; en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (o1 !== 2'b00 || latched !== 2'b00) begin
      errors++;
      $display("FAIL node5: o1=%b latched=%b required 00 00", o1, latched);
    end
    future_node = 5'd10; en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o1 !== 2'b00 || o2 !== 2'b00 || latched !== 2'b00) begin
      errors++;
      $display("FAIL en_low: o1=%b o2=%b latched=%b required 00 00 00", o1, o2, latched);
    end
    future_node = '0;
  endtask

  task automatic test_release;
    grip_ok = 2'b01;
    trigger(5'd10, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (latched !== 2'b01) begin
      errors++;
      $display("FAIL hold_ch0: latched=%b required 01", latched);
    end
    delatch = 2'b01;
    @(negedge clk);
    delatch = 2'b00;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o1 !== 2'b00 || o2 !== 2'b01 || latched !== 2'b00) begin
        errors++;
        $display("FAIL demag_ch0[%0d]: o1=%b o2=%b latched=%b required 00 01 00", k, o1, o2, latched);
      end
      @(negedge clk);
    end
    checks++;
    if (o1 !== 2'b00 || o2 !== 2'b00 || latched !== 2'b00) begin
      errors++;
      $display("FAIL after_demag: o1=%b o2=%b latched=%b required 00 00 00", o1, o2, latched);
    end
  endtask

  task automatic test_fault;
    grip_ok = 2'b00;
    trigger(5'd11, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (fault !== 2'b00 || latched !== 2'b01) begin
        errors++;
        $display("FAIL pre_fault[%0d]: fault=%b latched=%b required 00 01", k, fault, latched);
      end
    end
    @(negedge clk);
    checks++;
    if (fault !== 2'b01 || o1 !== 2'b00 || o2 !== 2'b00 || latched !== 2'b00) begin
      errors++;
      $display("FAIL fault_set: fault=%b o1=%b o2=%b latched=%b required 01 00 00 00", fault, o1, o2, latched);
    end
    delatch = 2'b01;
    @(negedge clk);
    delatch = 2'b00;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (fault !== 2'b00 || o2 !== 2'b00 || o1 !== 2'b00) begin
        errors++;
        $display("FAIL fault_clear[%0d]: fault=%b o1=%b o2=%b required 00 00 00", k, fault, o1, o2);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    grip_ok = 2'b01;
    trigger(5'd23, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    future_node = 5'd10; ch_sel = 1'b0; en = 1'b1; delatch = 2'b01;
    @(negedge clk);
    en = 1'b0; delatch = 2'b00; future_node = '0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o1 !== 2'b00 || o2 !== 2'b01) begin
        errors++;
        $display("FAIL b2b_demag[%0d]: o1=%b o2=%b required 00 01", k, o1, o2);
      end
      @(negedge clk);
    end
    repeat (2) begin
      checks++;
      if (o1 !== 2'b00 || o2 !== 2'b00 || latched !== 2'b00) begin
        errors++;
        $display("FAIL b2b_idle: o1=%b o2=%b latched=%b required 00 00 00", o1, o2, latched);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    trigger(5'd10, 1'b0, 1'b1);
    trigger(5'd22, 1'b1, 1'b1);
    checks++;
    if (o1 !== 2'b11 || latched !== 2'b11) begin
      errors++;
      $display("FAIL both_pullin: o1=%b latched=%b required 11 11", o1, latched);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o1, o2, latched, fault} !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid[%0d]: o1=%b o2=%b latched=%b fault=%b required all 0", k, o1, o2, latched, fault);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_latch();
    test_no_trigger();
    test_release();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
